// File: rtl/logic_unit_issue_queue.sv
// Issue-side front end for the 32-bit bitwise gate bank: evaluates one logic op per
// accepted request and queues result/tag/flags in an in-order FIFO for writeback.
module logic_unit_issue_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;

    logic [WIDTH-1:0] y_mem    [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic             zero_mem [DEPTH];
    logic             err_mem  [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          live_q;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] res_y;
    logic             res_err;
    logic             res_zero;

    always_comb begin
        res_y   = '0;
        res_err = 1'b0;
        case (in_op)
            OP_AND:  res_y = in_a & in_b;
            OP_OR:   res_y = in_a | in_b;
            OP_XOR:  res_y = in_a ^ in_b;
            OP_NOT:  res_y = ~in_a;
            OP_NAND: res_y = ~(in_a & in_b);
            OP_NOR:  res_y = ~(in_a | in_b);
            default: res_err = 1'b1;
        endcase
        res_zero = (res_y == '0);
    end

    // live_q keeps in_ready low until the first clock edge after reset release.
    assign in_ready  = live_q && (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            y_mem[wr_ptr_q]    <= res_y;
            tag_mem[wr_ptr_q]  <= in_tag;
            zero_mem[wr_ptr_q] <= res_zero;
            err_mem[wr_ptr_q]  <= res_err;
        end
    end

    always_comb begin
        out_y    = '0;
        out_tag  = '0;
        out_zero = 1'b0;
        out_err  = 1'b0;
        if (out_valid) begin
            out_y    = y_mem[rd_ptr_q];
            out_tag  = tag_mem[rd_ptr_q];
            out_zero = zero_mem[rd_ptr_q];
            out_err  = err_mem[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_logic_unit_issue_queue.sv
// Self-checking bench for logic_unit_issue_queue: queue-based reference model compared
// every cycle, plus directed literal checks for each operation and boundary case.
module tb_logic_unit_issue_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             in_op;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_y;
    logic [TAG_W-1:0]       out_tag;
    logic                   out_zero;
    logic                   out_err;
    logic [$clog2(DEPTH):0] count;

    logic_unit_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_tag(out_tag), .out_zero(out_zero), .out_err(out_err),
        .count(count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] y;
        logic [TAG_W-1:0] tag;
        logic             z;
        logic             e;
    } ent_t;

    ent_t mq[$];
    bit   alive = 1'b0;

    function automatic ent_t model_eval(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
        ent_t r;
        r.e = 1'b0;
        case (op)
            3'd0:    r.y = a & b;
            3'd1:    r.y = a | b;
            3'd2:    r.y = a ^ b;
            3'd3:    r.y = ~a;
            3'd4:    r.y = ~(a & b);
            3'd5:    r.y = ~(a | b);
            default: begin r.y = '0; r.e = 1'b1; end
        endcase
        r.z   = (r.y == '0);
        r.tag = t;
        return r;
    endfunction

    // Reference model: a plain queue with capacity DEPTH.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            alive = 1'b0;
        end else begin
            bit acc;
            bit rem;
            acc = in_valid && alive && (mq.size() < DEPTH);
            rem = out_ready && (mq.size() > 0);
            if (rem) void'(mq.pop_front());
            if (acc) mq.push_back(model_eval(in_op, in_a, in_b, in_tag));
            alive = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("count", 64'(count), 64'(mq.size()));
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(alive && (mq.size() < DEPTH)));
        if (mq.size() != 0) begin
            chk("out_y", 64'(out_y), 64'(mq[0].y));
            chk("out_tag", 64'(out_tag), 64'(mq[0].tag));
            chk("out_zero", 64'(out_zero), 64'(mq[0].z));
            chk("out_err", 64'(out_err), 64'(mq[0].e));
        end else begin
            chk("empty_outs", {out_y, 28'(out_tag), out_zero, out_err}, 64'd0);
        end
    end

    property p_hold;
        @(posedge clk) disable iff (!rst_n)
            (in_valid && !in_ready) |=> (in_valid && $stable(in_op) && $stable(in_a)
                                         && $stable(in_b) && $stable(in_tag));
    endproperty
    a_hold: assert property (p_hold) else begin
        n_fail++;
        $display("FAIL requester_hold at %0t", $time);
    end

    // Called at a negedge; returns at the negedge after the request was accepted.
    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
        int w;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = t;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("send_timeout", 64'd0, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    localparam logic [WIDTH-1:0] A0 = 32'hF0F0_1234;
    localparam logic [WIDTH-1:0] B0 = 32'h0FF0_00FF;

    logic [WIDTH-1:0] exp_y [6];
    logic [TAG_W-1:0] exp_tags [5];

    initial begin
        exp_y[0] = 32'h00F0_0034; exp_y[1] = 32'hFFF0_12FF; exp_y[2] = 32'hFF00_12CB;
        exp_y[3] = 32'h0F0F_EDCB; exp_y[4] = 32'hFF0F_FFCB; exp_y[5] = 32'h000F_ED00;
        exp_tags[0] = 4'd1; exp_tags[1] = 4'd2; exp_tags[2] = 4'd3;
        exp_tags[3] = 4'd4; exp_tags[4] = 4'd5;

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b0;
        idle(2);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // One request per gate function.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(3'(i), A0, B0, 4'(i + 1));
            chk($sformatf("op%0d_y", i), 64'(out_y), 64'(exp_y[i]));
            chk($sformatf("op%0d_tag", i), 64'(out_tag), 64'(i + 1));
            chk($sformatf("op%0d_valid", i), 64'(out_valid), 64'd1);
        end
        idle(2);

        // Fill with writeback stalled, then drain in order.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(3'd1, 32'(i), '0, 4'(i));
        in_valid = 1'b1; in_op = 3'd2; in_a = 32'h55; in_b = 32'hAA; in_tag = 4'd5;
        idle(2);
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bit acc_next;
            chk($sformatf("drain_tag%0d", i), 64'(out_tag), 64'(exp_tags[i]));
            acc_next = in_valid && in_ready;
            @(negedge clk);
            if (acc_next) in_valid = 1'b0;
        end
        chk("drained_count", 64'(count), 64'd0);
        chk("drained_valid", 64'(out_valid), 64'd0);

        // Back-to-back streaming across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_op = 3'(i % 6); in_a = 32'h0101_0101 * 32'(i + 1);
            in_b = ~(32'h0011_2233 * 32'(i)); in_tag = 4'(i);
            @(negedge clk);
            chk($sformatf("stream_count%0d", i), 64'(count), 64'd1);
        end
        in_valid = 1'b0;
        idle(2);

        // Illegal op, followed by a legal one.
        send(3'd6, A0, B0, 4'd9);
        chk("ill_y", 64'(out_y), 64'd0);
        chk("ill_zero", 64'(out_zero), 64'd1);
        chk("ill_err", 64'(out_err), 64'd1);
        chk("ill_tag", 64'(out_tag), 64'd9);
        send(3'd0, A0, B0, 4'd3);
        chk("post_ill_y", 64'(out_y), 64'h00F0_0034);
        chk("post_ill_err", 64'(out_err), 64'd0);
        send(3'd0, 32'hFFFF_0000, 32'h0000_FFFF, 4'd5);
        chk("and_zero_zero", 64'(out_zero), 64'd1);
        chk("and_zero_err", 64'(out_err), 64'd0);
        chk("and_zero_y", 64'(out_y), 64'd0);
        idle(2);

        // Asynchronous reset with entries pending.
        out_ready = 1'b0;
        send(3'd1, 32'h1, 32'h2, 4'd10);
        send(3'd1, 32'h3, 32'h4, 4'd11);
        send(3'd1, 32'h5, 32'h6, 4'd12);
        chk("pre_rst_count", 64'(count), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_count", 64'(count), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd0);
        chk("async_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_count", 64'(count), 64'd0);
        out_ready = 1'b1;
        send(3'd2, A0, B0, 4'd1);
        chk("rel_first_tag", 64'(out_tag), 64'd1);
        chk("rel_first_y", 64'(out_y), 64'hFF00_12CB);
        send(3'd3, A0, B0, 4'd2);
        chk("rel_second_tag", 64'(out_tag), 64'd2);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
